// File: rtl/mul_div_sequencer.sv
// Registered operand/result sequencer wrapped around a combinational signed multiplier/divider.
// Latency SETTLE+1 edges after the start edge (0 extra edges for divide-by-zero); result held until out_ready.
module mul_div_sequencer #(
   parameter int n      = 4,
   parameter int SETTLE = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                op_sel,
   input  logic signed [n:0]   a_in,
   input  logic signed [n:0]   b_in,
   input  logic signed [n+2:0] md_result,
   input  logic                out_ready,
   output logic signed [n:0]   md_x,
   output logic signed [n:0]   md_y,
   output logic                md_sel,
   output logic                busy,
   output logic                res_valid,
   output logic signed [n+2:0] res_out,
   output logic                div_by_zero
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_HOLD
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic signed [n:0]   md_x_q, md_x_d;
   logic signed [n:0]   md_y_q, md_y_d;
   logic                md_sel_q, md_sel_d;
   logic                busy_q, busy_d;
   logic                res_valid_q, res_valid_d;
   logic signed [n+2:0] res_out_q, res_out_d;
   logic                div_by_zero_q, div_by_zero_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      md_x_d        = md_x_q;
      md_y_d        = md_y_q;
      md_sel_d      = md_sel_q;
      res_valid_d   = res_valid_q;
      res_out_d     = res_out_q;
      div_by_zero_d = div_by_zero_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               md_x_d        = a_in;
               md_y_d        = b_in;
               md_sel_d      = op_sel;
               div_by_zero_d = 1'b0;
               // Zero divisor never reaches the divider's result path
               if (op_sel && (b_in == '0)) begin
                  res_out_d     = '0;
                  div_by_zero_d = 1'b1;
                  res_valid_d   = 1'b1;
                  state_d       = ST_HOLD;
               end else begin
                  cnt_d   = CW'(SETTLE - 1);
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_CAPTURE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_CAPTURE: begin
            res_out_d   = md_result;
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         md_x_q        <= '0;
         md_y_q        <= '0;
         md_sel_q      <= 1'b0;
         busy_q        <= 1'b0;
         res_valid_q   <= 1'b0;
         res_out_q     <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         md_x_q        <= md_x_d;
         md_y_q        <= md_y_d;
         md_sel_q      <= md_sel_d;
         busy_q        <= busy_d;
         res_valid_q   <= res_valid_d;
         res_out_q     <= res_out_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign md_x        = md_x_q;
   assign md_y        = md_y_q;
   assign md_sel      = md_sel_q;
   assign busy        = busy_q;
   assign res_valid   = res_valid_q;
   assign res_out     = res_out_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Random and directed checks of mul_div_sequencer (SETTLE=1 and SETTLE=3 instances) against a reference model.
module tb_mul_div_sequencer;

   localparam int N = 4;
   localparam int W = N + 3;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start [2];
   logic                op_sel;
   logic signed [N:0]   a_in, b_in;
   logic                out_ready;
   logic signed [W-1:0] md_result [2];
   logic signed [N:0]   md_x [2];
   logic signed [N:0]   md_y [2];
   logic                md_sel [2];
   logic                busy [2];
   logic                res_valid [2];
   logic signed [W-1:0] res_out [2];
   logic                div_by_zero [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Stand-in for the combinational unit; returns junk on a zero divisor
   function automatic logic signed [W-1:0] md_unit(input logic signed [N:0] x,
                                                  input logic signed [N:0] y,
                                                  input logic sel);
      logic signed [W-1:0] xw, yw;
      xw = x;
      yw = y;
      if (sel) return (yw == 0) ? W'(42) : xw / yw;
      return xw * yw;
   endfunction

   function automatic logic signed [W-1:0] ref_res(input int a, input int b, input bit sel);
      int r;
      if (sel) r = (b == 0) ? 0 : a / b;
      else     r = a * b;
      return W'(r);
   endfunction

   function automatic int settle_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign md_result[g] = md_unit(md_x[g], md_y[g], md_sel[g]);
      mul_div_sequencer #(.n(N), .SETTLE((g == 0) ? 1 : 3)) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .start       (start[g]),
         .op_sel      (op_sel),
         .a_in        (a_in),
         .b_in        (b_in),
         .md_result   (md_result[g]),
         .out_ready   (out_ready),
         .md_x        (md_x[g]),
         .md_y        (md_y[g]),
         .md_sel      (md_sel[g]),
         .busy        (busy[g]),
         .res_valid   (res_valid[g]),
         .res_out     (res_out[g]),
         .div_by_zero (div_by_zero[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic scramble_inputs();
      a_in   = (N+1)'($urandom);
      b_in   = (N+1)'($urandom);
      op_sel = 1'($urandom);
   endtask

   task automatic do_op(input int d, input int a, input int b, input bit sel, input int hold);
      logic signed [N:0]   a_v, b_v;
      logic signed [W-1:0] er;
      bit                  edz;
      int                  lat, k;
      a_v = (N+1)'(a);
      b_v = (N+1)'(b);
      er  = ref_res(a, b, sel);
      edz = sel && (b == 0);
      lat = edz ? 0 : settle_of(d) + 1;

      @(negedge clk);
      a_in = a_v; b_in = b_v; op_sel = sel; start[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[d] = 1'b0;
      scramble_inputs();
      chk("busy_after_start", busy[d], 1);
      k = 0;
      while (!res_valid[d] && k < 20) begin
         chk("md_x_settle", md_x[d], a_v);
         chk("md_y_settle", md_y[d], b_v);
         chk("md_sel_settle", md_sel[d], sel);
         chk("busy_settle", busy[d], 1);
         @(posedge clk);
         @(negedge clk);
         scramble_inputs();
         k++;
      end
      chk("latency", k, lat);
      chk("res_out", res_out[d], er);
      chk("div_by_zero", div_by_zero[d], edz);
      chk("md_y_result", md_y[d], b_v);

      repeat (hold) begin
         out_ready = 1'b0;
         start[d]  = 1'($urandom);
         scramble_inputs();
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", res_valid[d], 1);
         chk("hold_res", res_out[d], er);
         chk("hold_md_x", md_x[d], a_v);
         chk("hold_md_y", md_y[d], b_v);
         chk("hold_busy", busy[d], 1);
      end

      // start on the HOLD-exit edge must be ignored
      out_ready = 1'b1;
      start[d]  = 1'b1;
      scramble_inputs();
      @(posedge clk);
      @(negedge clk);
      chk("exit_valid", res_valid[d], 0);
      chk("exit_busy", busy[d], 0);
      chk("idle_md_x_kept", md_x[d], a_v);
      start[d]  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; start[0] = 1'b0; start[1] = 1'b0;
      op_sel = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", busy[d], 0);
         chk("rst_valid", res_valid[d], 0);
         chk("rst_res", res_out[d], 0);
         chk("rst_md_x", md_x[d], 0);
         chk("rst_dbz", div_by_zero[d], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      do_op(0,   3,  5, 0, 0);
      do_op(0,  -7,  6, 0, 0);
      do_op(0,  13, -4, 1, 0);
      do_op(0, -16, -1, 1, 0);
      do_op(0,   9,  0, 1, 0);
      do_op(0,   3,  5, 0, 5);
      do_op(1,   2,  4, 0, 0);
      do_op(1,  -5,  0, 1, 2);

      for (int i = 0; i < 40; i++) begin
         int d, a, b;
         bit sel;
         d   = $urandom_range(0, 1);
         a   = $urandom_range(0, 31) - 16;
         b   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31) - 16;
         sel = 1'($urandom);
         do_op(d, a, b, sel, $urandom_range(0, 3));
      end

      // Async reset in the middle of SETTLE on the SETTLE=3 instance
      do_op(1, 2, 4, 0, 0);
      @(negedge clk);
      a_in = 5; b_in = 3; op_sel = 1'b0; start[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[1] = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy[1], 0);
      chk("arst_valid", res_valid[1], 0);
      chk("arst_res", res_out[1], 0);
      chk("arst_md_x", md_x[1], 0);
      chk("arst_md_y", md_y[1], 0);
      chk("arst_md_sel", md_sel[1], 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(1, 1, 1, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
- Registered control stage upstream of the combinational signed multiplier/divider. Captures operands and operation on a start pulse and drives them, held stable, to that unit.
- Waits a programmable settle time, then captures the unit's result into an output register. Presents the result with a valid/ready handshake.
- Screens divide-by-zero so the combinational divider is never relied on for Y = 0.

Parameters:
- n, 4, operand magnitude width; operands are n+1 bits signed, result is n+3 bits signed (matches the multiplier/divider).
- SETTLE, 1, number of clock cycles the operands are held before the result is sampled (≥1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_sel  input  1  0 = multiply, 1 = divide
- a_in  input  n+1  signed operand X
- b_in  input  n+1  signed operand Y
- md_result  input  n+3  signed result returned by the multiplier/divider
- out_ready  input  1  consumer accepts result
- md_x  output  n+1  registered X to multiplier/divider
- md_y  output  n+1  registered Y to multiplier/divider
- md_sel  output  1  registered selection to multiplier/divider
- busy  output  1  high in every state except IDLE
- res_valid  output  1  result register valid
- res_out  output  n+3  registered signed result
- div_by_zero  output  1  qualifies res_out; high when the divide had Y = 0

Behaviour:
- Reset (async, rst_n low): state IDLE; md_x, md_y, md_sel, res_out, settle counter = 0; busy, res_valid, div_by_zero = 0. Reset mid-operation aborts immediately and discards any pending result.
- States: IDLE, SETTLE, CAPTURE, HOLD.
- IDLE:
  - On an edge with start = 1: register a_in→md_x, b_in→md_y, op_sel→md_sel, clear div_by_zero.
  - If op_sel = 1 and b_in = 0: go directly to HOLD with res_out = 0, div_by_zero = 1, res_valid = 1.
  - Otherwise: load the counter with SETTLE-1 and go to SETTLE.
- SETTLE: decrement the counter each edge; at count 0 go to CAPTURE. md_x, md_y and md_sel stay constant.
- CAPTURE: on the next edge, res_out ← md_result, res_valid ← 1, go to HOLD.
- Latency: start sampled at edge E0 → res_valid high after edge E0+SETTLE+1. With SETTLE = 1 that is 2 edges. The divide-by-zero path takes 1 edge.
- HOLD:
  - res_out, div_by_zero and md_* remain stable.
  - On an edge with out_ready = 1: res_valid ← 0, go to IDLE.
  - out_ready low: hold indefinitely.
- start is ignored while busy, including the HOLD-exit edge. A new request is accepted only on an edge where the state is already IDLE, so the minimum issue interval is SETTLE+3 cycles.
- out_ready is a don't-care outside HOLD.
- Arithmetic: the sequencer does not modify md_result.
  - Multiply overflow beyond n+3 bits wraps per the multiplier/divider.
  - Division truncates toward zero per the multiplier/divider.
  - The most-negative operand divided by -1 fits in n+3 bits and must pass unflagged.
- md_* outputs retain their last values in IDLE; they are not cleared after completion.

Test Plan:
- Reset, then start, op_sel = 0, a = 3, b = 5, SETTLE = 1, out_ready = 1 → res_valid rises 2 edges after start; res_out = 15; div_by_zero = 0; busy drops the edge after.
- Multiply a = -7, b = 6 → res_out = -42 (7'b1010110). Then divide a = 13, b = -4 → res_out = -3. Then divide a = -16, b = -1 → res_out = 16, div_by_zero = 0.
- Divide a = 9, b = 0 → one edge later res_valid = 1, res_out = 0, div_by_zero = 1; md_y = 0 driven but never sampled.
- Backpressure: result 15 pending, out_ready held low for 5 cycles with start pulsing and operands changing → res_out, md_x and md_y unchanged, busy = 1. Raise out_ready → res_valid clears, returns to IDLE, next start accepted.
- SETTLE = 3, multiply a = 2, b = 4 → res_valid exactly 4 edges after start, res_out = 8.
- Assert rst_n low asynchronously during SETTLE → busy, res_valid, res_out and md_* go to 0 immediately, without waiting for a clock edge. After release, a new multiply 1 × 1 = 1 completes normally.
